// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer bundle: request and operands in,
// pipeline stall and the single 64-bit HI/LO write out.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo_cur;
    logic        flush;
    logic        stall;
    logic        hilo_we;
    logic [63:0] hilo_o;

    modport master (
        output start, op, a, b, hilo_cur, flush,
        input  stall, hilo_we, hilo_o
    );

    modport slave (
        input  start, op, a, b, hilo_cur, flush,
        output stall, hilo_we, hilo_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: fixed-latency multiply, 32-step restoring divide and MTHI/MTLO,
// each retiring as one write pulse to hilo_reg while EX is held by stall.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_ctrl_if.slave   bus
);

    localparam int CNT_W = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) + 1 : 6;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nxt;
    logic   stall_c, we_c;
    logic   accept, sgn_div;
    logic   mul_last, div_last;

    logic [CNT_W-1:0] cnt;

    logic               mul_uns_p0;
    logic signed [31:0] a_p0, b_p0;
    logic               qneg_p0, rneg_p0;
    logic [31:0]        quo_p1, rem_p1, dvs_p1;

    logic signed [63:0] ma, mb, prod;
    logic [32:0]        rem_sh, rem_sub;
    logic               fit;
    logic [31:0]        quo_nxt, rem_nxt;
    logic [63:0]        hilo_q;

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    assign accept   = (state == IDLE) && bus.start && (bus.op <= OP_MTLO) && !bus.flush;
    assign sgn_div  = (bus.op == OP_DIV);
    assign mul_last = (cnt == CNT_W'(MUL_CYCLES - 1));
    assign div_last = (cnt == CNT_W'(31));

    // ---- stage p0: operands captured on accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_uns_p0 <= (bus.op == OP_MULTU);
            a_p0       <= bus.a;
            b_p0       <= bus.b;
            dvs_p1     <= mag(bus.b, sgn_div);
            quo_p1     <= mag(bus.a, sgn_div);
            rem_p1     <= '0;
            qneg_p0    <= sgn_div & (bus.a[31] ^ bus.b[31]);
            rneg_p0    <= sgn_div & bus.a[31];
        end else if (state == DIV) begin
            quo_p1 <= quo_nxt;
            rem_p1 <= rem_nxt;
        end
    end

    // ---- stage p1: multiply from captured operands, one restoring divide step ----
    always_comb begin
        ma = mul_uns_p0 ? {32'd0, a_p0} : {{32{a_p0[31]}}, a_p0};
        mb = mul_uns_p0 ? {32'd0, b_p0} : {{32{b_p0[31]}}, b_p0};
        prod = ma * mb;

        rem_sh  = {rem_p1, quo_p1[31]};
        rem_sub = rem_sh - {1'b0, dvs_p1};
        fit     = (rem_sh >= {1'b0, dvs_p1});
        rem_nxt = fit ? rem_sub[31:0] : rem_sh[31:0];
        quo_nxt = {quo_p1[30:0], fit};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == MUL || state == DIV) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // ---- stage p2: result register, loaded on the transition into DONE ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_q <= '0;
        end else if (accept) begin
            case (bus.op)
                OP_DIV, OP_DIVU: if (bus.b == 32'd0) hilo_q <= {bus.a, 32'hFFFF_FFFF};
                OP_MTHI:         hilo_q <= {bus.a, bus.hilo_cur[31:0]};
                OP_MTLO:         hilo_q <= {bus.hilo_cur[63:32], bus.a};
                default:         ;
            endcase
        end else if (!bus.flush) begin
            if (state == MUL && mul_last) begin
                hilo_q <= prod;
            end else if (state == DIV && div_last) begin
                hilo_q <= {apply_sign(rem_nxt, rneg_p0), apply_sign(quo_nxt, qneg_p0)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        we_c      = 1'b0;
        unique case (state)
            IDLE: begin
                stall_c = accept;
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: state_nxt = MUL;
                        OP_DIV, OP_DIVU:   state_nxt = (bus.b == 32'd0) ? DONE : DIV;
                        default:           state_nxt = DONE;
                    endcase
                end
            end
            MUL: begin
                stall_c = 1'b1;
                if (bus.flush)     state_nxt = IDLE;
                else if (mul_last) state_nxt = DONE;
            end
            DIV: begin
                stall_c = 1'b1;
                if (bus.flush)     state_nxt = IDLE;
                else if (div_last) state_nxt = DONE;
            end
            DONE: begin
                we_c      = !bus.flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset must force the outputs low even while start is still asserted.
    assign bus.stall   = rst & stall_c;
    assign bus.hilo_we = rst & we_c;
    assign bus.hilo_o  = hilo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, flush and reset behaviour.
module tb_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.hilo_cur = 64'd0;
        bus.flush    = 1'b0;
    endtask

    // Issue one op at cycle T; expect stall T..T+lat-1 and a single write at T+lat.
    task automatic run_op(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [63:0] cur_i,
                          input int lat, input logic [63:0] exp);
        int bad;
        bad = 0;
        bus.start    = 1'b1;
        bus.op       = op_i;
        bus.a        = a_i;
        bus.b        = b_i;
        bus.hilo_cur = cur_i;
        @(negedge clk);
        check({tag, " stall@T"}, bus.stall, 1);
        next_cycle();
        idle_inputs();
        bus.a = 32'hA5A5_A5A5;
        bus.b = 32'h5A5A_5A5A;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                if (!bus.stall || bus.hilo_we) bad++;
            end else begin
                check({tag, " we@T+lat"}, bus.hilo_we, 1);
                check({tag, " stall@T+lat"}, bus.stall, 0);
                check({tag, " hilo_o"}, bus.hilo_o, exp);
            end
            next_cycle();
        end
        check({tag, " busy window"}, 64'(bad), 0);
    endtask

    initial begin
        int bad_we, bad_st;
        idle_inputs();
        rst = 1'b0;
        #3;
        check("reset stall", bus.stall, 0);
        check("reset we", bus.hilo_we, 0);
        check("reset hilo_o", bus.hilo_o, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        next_cycle();

        run_op("MULT -3*7",   3'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, 3, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("MULTU",       3'd1, 32'hFFFF_FFFD, 32'd7, 64'd0, 3, 64'h0000_0006_FFFF_FFEB);
        run_op("MULT -3*-5",  3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd0, 3, 64'h0000_0000_0000_000F);
        run_op("DIVU 100/7",  3'd3, 32'd100, 32'd7, 64'd0, 33, 64'h0000_0002_0000_000E);
        run_op("DIVU b2b",    3'd3, 32'hFFFF_FFFF, 32'h10, 64'd0, 33, 64'h0000_000F_0FFF_FFFF);
        run_op("DIV -7/2",    3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("DIV 7/-2",    3'd2, 32'd7, 32'hFFFF_FFFE, 64'd0, 33, 64'h0000_0001_FFFF_FFFD);
        run_op("DIV -7/-2",   3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'd0, 33, 64'hFFFF_FFFF_0000_0003);
        run_op("DIV min/-1",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 33, 64'h0000_0000_8000_0000);
        run_op("DIVU min/2",  3'd3, 32'h8000_0000, 32'd2, 64'd0, 33, 64'h0000_0000_4000_0000);
        run_op("DIV 5/0",     3'd2, 32'd5, 32'd0, 64'd0, 1, 64'h0000_0005_FFFF_FFFF);
        run_op("MTHI",        3'd4, 32'hDEAD_BEEF, 32'd0, 64'h1111_2222_3333_4444, 1, 64'hDEAD_BEEF_3333_4444);
        run_op("MTLO",        3'd5, 32'hDEAD_BEEF, 32'd0, 64'h1111_2222_3333_4444, 1, 64'h1111_2222_DEAD_BEEF);

        // DIVU squashed at T+10
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        check("flush div stall@T", bus.stall, 1);
        next_cycle();
        idle_inputs();
        repeat (9) next_cycle();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush div stall@T+10", bus.stall, 1);
        next_cycle();
        bus.flush = 1'b0;
        bad_we = 0;
        bad_st = 0;
        for (int k = 11; k <= 40; k++) begin
            @(negedge clk);
            if (bus.hilo_we) bad_we++;
            if (bus.stall)   bad_st++;
            next_cycle();
        end
        check("flush div no write", 64'(bad_we), 0);
        check("flush div stall low", 64'(bad_st), 0);
        check("flush div hilo held", bus.hilo_o, 64'h1111_2222_DEAD_BEEF);

        // flush while in DONE
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678;
        @(negedge clk);
        check("flush done stall@T", bus.stall, 1);
        next_cycle();
        idle_inputs();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush done we", bus.hilo_we, 0);
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush done we after", bus.hilo_we, 0);
        next_cycle();

        // flush beats start in IDLE
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
        @(negedge clk);
        check("flush prio stall@T", bus.stall, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("flush prio stall@T+1", bus.stall, 0);
        check("flush prio we@T+1", bus.hilo_we, 0);
        next_cycle();

        // asynchronous reset in the middle of a multiply
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'hFFFF_FFFD; bus.b = 32'd7;
        next_cycle();
        idle_inputs();
        check("rst mid-mul stall before", bus.stall, 1);
        #2 rst = 1'b0;
        #1;
        check("rst mid-mul stall", bus.stall, 0);
        check("rst mid-mul we", bus.hilo_we, 0);
        check("rst mid-mul hilo_o", bus.hilo_o, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        next_cycle();

        // invalid op ignored
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clk);
        check("op6 stall@T", bus.stall, 0);
        next_cycle();
        bus.op = 3'd7;
        @(negedge clk);
        check("op7 stall", bus.stall, 0);
        check("op6 we@T+1", bus.hilo_we, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("op7 we", bus.hilo_we, 0);
        check("op6/7 hilo_o", bus.hilo_o, 0);
        next_cycle();

        run_op("MULT after rst", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, 3, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in EX that owns all writes to the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and stalls the pipeline while busy.
- Runs a fixed-latency multiply or a 32-iteration restoring divide, then pulses a single 64-bit write into hilo_reg.
- Supports flush for exception/branch squash.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL state before result write (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  EX holds a HI/LO-writing instruction this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 invalid.
- a  in  32  rs operand.
- b  in  32  rt operand.
- hilo_cur  in  64  current {HI,LO} from hilo_reg; used by MTHI/MTLO to preserve the untouched half.
- flush  in  1  squash the in-flight operation.
- stall  out  1  freeze IF..EX.
- hilo_we  out  1  write enable to hilo_reg.
- hilo_o  out  64  {HI,LO} write data.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hilo_o=0, counters=0, stall=0, hilo_we=0.
- States: IDLE, MUL, DIV, DONE.
- Accept: in IDLE with start=1, flush=0 and op≤5 at cycle T, latch a, b, op and hilo_cur.
  - op 0/1 -> MUL.
  - op 2/3 with b≠0 -> DIV.
  - op 2/3 with b=0 -> DONE; hilo_o={a, 32'hFFFFFFFF}.
  - op 4 -> DONE; hilo_o={a, hilo_cur[31:0]}.
  - op 5 -> DONE; hilo_o={hilo_cur[63:32], a}.
- start with op 6/7 is ignored: no stall, stays IDLE. start outside IDLE is ignored.
- stall = (IDLE & start & op≤5 & ~flush) | MUL | DIV. stall is low in DONE, so EX advances in the same cycle the write happens. Every accepted op costs at least 1 stall cycle.
- MUL:
  - Full 64-bit product: signed for MULT, unsigned for MULTU; result register internally pipelined.
  - Count MUL_CYCLES cycles, then DONE. hilo_o={prod[63:32], prod[31:0]}.
  - hilo_we asserted at T+1+MUL_CYCLES.
- DIV:
  - Operate on magnitudes (signed op: negate negative operands).
  - One restoring quotient bit per cycle, 32 cycles, then DONE.
  - Sign fixup is combinational on entry to DONE: quotient sign = a[31]^b[31]; remainder sign = a[31] (DIV only).
  - hilo_o={remainder, quotient}; hilo_we at T+33. Divide-by-zero: hilo_we at T+1.
- DONE: hilo_we = ~flush for exactly one cycle; next state IDLE unconditionally. A new op can be accepted in the cycle after DONE.
- hilo_o holds its last value outside DONE; consumers sample it only when hilo_we=1.
- flush in MUL/DIV/DONE: next state IDLE, no hilo_we pulse (combinationally suppressed in DONE), stall drops the next cycle. flush has priority over start in IDLE.
- Arithmetic edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
  - Magnitude of 0x80000000 is treated as unsigned 2^31.
- Reset mid-operation aborts immediately: no write, outputs forced to reset values.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, MUL_CYCLES=2 -> stall high T..T+2; hilo_we only at T+3 with hilo_o=0xFFFFFFFF_FFFFFFEB. MULTU same operands -> 0x00000006_FFFFFFEB.
- DIVU a=100, b=7 -> stall high T..T+32; hilo_we at T+33 with hilo_o=0x00000002_0000000E. Back-to-back DIVU accepted at T+34.
- DIV a=0xFFFFFFF9 (-7), b=2 -> hilo_o=0xFFFFFFFF_FFFFFFFD (hi=-1, lo=-3). DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- DIV a=5, b=0 -> hilo_we at T+1, hilo_o=0x00000005_FFFFFFFF. MTHI a=0xDEADBEEF with hilo_cur=0x11112222_33334444 -> hilo_we at T+1, hilo_o=0xDEADBEEF_33334444. MTLO -> 0x11112222_DEADBEEF.
- DIVU started at T, flush=1 at T+10 -> state IDLE at T+11, stall=0 from T+11, no hilo_we through T+40. flush during DONE -> hilo_we stays 0.
- rst pulled low asynchronously mid-MUL (between clock edges) -> stall, hilo_we, hilo_o=0 immediately. After release, op=6 with start=1 -> no stall, no write.
